// File: rtl/gridx_mem_pkg.sv
// gridx_mem_pkg: power states and default bank geometry shared by the SRAM bank logic.
package gridx_mem_pkg;
  typedef enum logic [1:0] {OFF, WAKE, ON} pwr_state_e;
  localparam int DEF_ADDR_BITS = 8;
  localparam int DEF_DATA_WIDTH = 64;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin picker; on a strobed grant the pointer moves just past the winner.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               adv_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o
);
  logic [IW-1:0] ptr_q, ptr_d, cand;
  // scanning downwards lets the candidate nearest the pointer win
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    ptr_d = ptr_q;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (req_i[cand]) begin
        gnt_o = '0;
        gnt_o[cand] = 1'b1;
        idx_o = cand;
        ptr_d = IW'((int'(cand) + 1) % NUM_REQ);
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else if (adv_i) ptr_q <= ptr_d;
  end
endmodule

// File: rtl/sram_bank_arbiter.sv
// sram_bank_arbiter: shares one SRAM bank among NUM_REQ requesters with independent
// read/write round-robin arbitration and idle power-down of the bank.
module sram_bank_arbiter
  import gridx_mem_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_BITS    = DEF_ADDR_BITS,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_read_valid,
  input  logic [NUM_REQ*ADDR_BITS-1:0]  req_read_address,
  output logic [NUM_REQ-1:0]            req_read_grant,
  output logic [NUM_REQ-1:0]            req_read_ready,
  output logic [DATA_WIDTH-1:0]         req_read_data,
  input  logic [NUM_REQ-1:0]            req_write_valid,
  input  logic [NUM_REQ*ADDR_BITS-1:0]  req_write_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_write_data,
  output logic [NUM_REQ-1:0]            req_write_grant,
  output logic                          bank_enable,
  output logic                          bank_read_valid,
  output logic [ADDR_BITS-1:0]          bank_read_address,
  output logic                          bank_write_valid,
  output logic [ADDR_BITS-1:0]          bank_write_address,
  output logic [DATA_WIDTH-1:0]         bank_write_data,
  input  logic                          bank_read_ready,
  input  logic [DATA_WIDTH-1:0]         bank_read_data,
  input  logic                          bank_write_ready,
  output logic                          bank_on
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(IDLE_TIMEOUT + 2);
  pwr_state_e state_q;
  logic [CW-1:0] idle_q;
  logic [NUM_REQ-1:0] rd_gnt, wr_gnt, req_read_grant_q, req_write_grant_q;
  logic [IW-1:0] rd_idx, wr_idx, rd_owner_q, rd_ret_q;
  logic bank_read_valid_q, bank_write_valid_q, rd_pend_q;
  logic on, any_req, busy, timeout, unused_ok;
  logic [ADDR_BITS-1:0] bank_read_address_q, bank_write_address_q;
  logic [DATA_WIDTH-1:0] bank_write_data_q;
  assign on = state_q == ON;
  assign any_req = |{req_read_valid, req_write_valid};
  assign busy = any_req || |{req_read_grant_q, req_write_grant_q} || bank_read_valid_q || rd_pend_q;
  assign timeout = IDLE_TIMEOUT != 0 && on && !busy && idle_q == CW'(IDLE_TIMEOUT - 1);
  assign unused_ok = bank_write_ready;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
    .clk, .reset, .req_i(req_read_valid & ~req_read_grant_q & {NUM_REQ{on}}),
    .adv_i(on), .gnt_o(rd_gnt), .idx_o(rd_idx)
  );
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
    .clk, .reset, .req_i(req_write_valid & ~req_write_grant_q & {NUM_REQ{on}}),
    .adv_i(on), .gnt_o(wr_gnt), .idx_o(wr_idx)
  );
  // the bank answers one cycle after bank_read_valid, so the owner rides a two-stage pipe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= OFF;
      idle_q <= '0;
      req_read_grant_q <= '0;
      req_write_grant_q <= '0;
      bank_read_valid_q <= 1'b0;
      bank_write_valid_q <= 1'b0;
      bank_read_address_q <= '0;
      bank_write_address_q <= '0;
      bank_write_data_q <= '0;
      rd_owner_q <= '0;
      rd_pend_q <= 1'b0;
      rd_ret_q <= '0;
    end else begin
      state_q <= state_q == OFF ? (any_req ? WAKE : OFF) : state_q == WAKE ? ON : timeout ? OFF : ON;
      idle_q <= on && !busy && !timeout ? idle_q + 1'b1 : '0;
      req_read_grant_q <= rd_gnt;
      req_write_grant_q <= wr_gnt;
      bank_read_valid_q <= |rd_gnt;
      bank_write_valid_q <= |wr_gnt;
      bank_read_address_q <= |rd_gnt ? req_read_address[rd_idx*ADDR_BITS +: ADDR_BITS] : '0;
      bank_write_address_q <= |wr_gnt ? req_write_address[wr_idx*ADDR_BITS +: ADDR_BITS] : '0;
      bank_write_data_q <= |wr_gnt ? req_write_data[wr_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
      rd_owner_q <= rd_idx;
      rd_pend_q <= bank_read_valid_q;
      rd_ret_q <= rd_owner_q;
    end
  end
  assign bank_enable = state_q != OFF;
  assign bank_on = on;
  assign req_read_grant = req_read_grant_q;
  assign req_write_grant = req_write_grant_q;
  assign bank_read_valid = bank_read_valid_q;
  assign bank_read_address = bank_read_address_q;
  assign bank_write_valid = bank_write_valid_q;
  assign bank_write_address = bank_write_address_q;
  assign bank_write_data = bank_write_data_q;
  assign req_read_ready = rd_pend_q && bank_read_ready ? NUM_REQ'(1) << rd_ret_q : '0;
  assign req_read_data = rd_pend_q && bank_read_ready ? bank_read_data : '0;
endmodule
